// File: rtl/pipeline_elastic_buffer.sv
// pipeline_elastic_buffer: small first-word-fall-through FIFO placed after the
// 16-bit register pipeline. It accepts the pipeline's free-running stream,
// hands words to the consumer over a valid/ready handshake, and raises a
// sticky overflow flag whenever a word has to be dropped because the buffer
// is full.
module pipeline_elastic_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              datain_valid,
  output logic              datain_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              dataout_valid,
  input  logic              dataout_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Status decode straight from the registered occupancy count.
  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign datain_ready  = !full;
  assign dataout_valid = !empty;

  // Handshake qualification: a full buffer never accepts, even when it is
  // being popped in the same cycle (no pass-through), and an empty buffer
  // ignores dataout_ready so the count cannot underflow.
  assign push = datain_valid && !full;
  assign pop  = dataout_ready && !empty;

  // Storage write port.
  // NOTE: the data array carries no reset; every entry is written before it
  // can be observed and dataout is masked while empty, so clearing it would
  // only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= datain;
    end
  end

  // Pointer, occupancy and sticky overflow state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (datain_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head-of-queue read, forced to zero while nothing is stored.
  // NOTE: the output gets a default before the conditional so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dataout = '0;
    if (!empty) begin
      dataout = mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_pipeline_elastic_buffer.sv
// tb_pipeline_elastic_buffer: randomized and directed checks of the elastic
// buffer against a queue-based reference model of FIFO behaviour.
module tb_pipeline_elastic_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] datain;
  logic              datain_valid;
  logic              datain_ready;
  logic [DATA_W-1:0] dataout;
  logic              dataout_valid;
  logic              dataout_ready;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: the stored words in arrival order plus the sticky flag.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;

  pipeline_elastic_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .datain(datain), .datain_valid(datain_valid), .datain_ready(datain_ready),
    .dataout(dataout), .dataout_valid(dataout_valid), .dataout_ready(dataout_ready),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge (inputs already set), update the model, and
  // return on the following falling edge where outputs are compared.
  task automatic clk_edge();
    bit do_push, do_pop;
    do_push = datain_valid && (q.size() < DEPTH);
    do_pop  = dataout_ready && (q.size() > 0);
    if (datain_valid && q.size() == DEPTH) m_ovf = 1'b1;
    @(posedge clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(datain);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    datain = '0; datain_valid = 1'b0; dataout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    datain = w; datain_valid = 1'b1; dataout_ready = 1'b0;
    clk_edge();
    datain_valid = 1'b0;
  endtask

  // Asynchronous reset between edges, with words already queued.
  task automatic test_reset();
    apply_reset();
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    #2 rst_n = 1'b0;
    #1;
    total++; if (dataout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dataout_valid); end
    total++; if (datain_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", datain_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (dataout !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", dataout); end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    push_word(16'hA5A5);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (dataout_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", dataout_valid); end
    total++; if (dataout !== 16'hA5A5) begin bad++; $display("FAIL single_data got=%h exp=a5a5", dataout); end
    dataout_ready = 1'b1;
    clk_edge();
    dataout_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    total++; if (dataout !== 16'h0000) begin bad++; $display("FAIL single_pop_data got=%h exp=0000", dataout); end
    total++; if (dataout_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", dataout_valid); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (datain_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", datain_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    push_word(16'h0005);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_ovf_count got=%0d exp=4", count); end
    dataout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (dataout !== 16'(i)) begin bad++; $display("FAIL drain_word got=%h exp=%h", dataout, 16'(i)); end
      clk_edge();
    end
    dataout_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_word(16'hB000);
    push_word(16'hB001);
    datain_valid = 1'b1; dataout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      datain = 16'hB002 + 16'(i);
      total++;
      if (dataout !== q[0]) begin bad++; $display("FAIL b2b_head got=%h exp=%h", dataout, q[0]); end
      clk_edge();
      total++;
      if (count !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
    end
    datain_valid = 1'b0; dataout_ready = 1'b0;
    total++; if (dataout !== 16'hB00A) begin bad++; $display("FAIL b2b_final got=%h exp=b00a", dataout); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(16'hC000 + 16'(i));
    datain = 16'hCCCC; datain_valid = 1'b1; dataout_ready = 1'b1;
    clk_edge();
    datain_valid = 1'b0; dataout_ready = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fullpop_ovf got=%b exp=1", overflow); end
    total++; if (dataout !== 16'hC001) begin bad++; $display("FAIL fullpop_head got=%h exp=c001", dataout); end
    dataout_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      total++;
      if (dataout !== 16'hC000 + 16'(i)) begin bad++; $display("FAIL fullpop_drain got=%h exp=%h", dataout, 16'hC000 + 16'(i)); end
      clk_edge();
    end
    dataout_ready = 1'b0;
    total++; if (dataout_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", dataout_valid); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp_head;
    apply_reset();
    datain_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (c == 100) begin
        #2 rst_n = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL stream_rst_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_rst_ovf got=%b exp=0", overflow); end
        total++; if (dataout_valid !== 1'b0) begin bad++; $display("FAIL stream_rst_valid got=%b exp=0", dataout_valid); end
        q.delete(); m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      datain = 16'($urandom);
      dataout_ready = 1'($urandom_range(0, 1));
      clk_edge();
      exp_head = (q.size() > 0) ? q[0] : '0;
      total++; if (count !== CNT_W'(q.size())) begin bad++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, count, q.size()); end
      total++; if (dataout !== exp_head) begin bad++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, dataout, exp_head); end
      total++; if (dataout_valid !== (q.size() > 0)) begin bad++; $display("FAIL stream_valid c=%0d got=%b", c, dataout_valid); end
      total++; if (datain_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL stream_ready c=%0d got=%b", c, datain_ready); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL stream_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
    end
    datain_valid = 1'b0; dataout_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    datain = '0; datain_valid = 1'b0; dataout_ready = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_full_pop();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
